switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
Input-side counterpart to the board LED drivers. Cleans the NUM_CH raw slide-switch/push-button pins: a 2-FF synchronizer feeds a per-channel debounce FSM. The block outputs a stable level, one-cycle rise/fall event pulses and a press-toggle bit. Downstream control logic and LED blinkers consume these outputs instead of raw pins.

Parameters:
NUM_CH, 4, number of independent switch channels (>=1)
DEBOUNCE_CYCLES, 2500000, cycles the input must be stable before acceptance (20 ms at 125 MHz); must be >=2
CNT_W, $clog2(DEBOUNCE_CYCLES), derived localparam, width of each channel counter

Ports:
clk_125  in  1  system clock, 125 MHz
reset_n  in  1  asynchronous, active-low reset
sw_in  in  NUM_CH  raw, asynchronous switch/button pins
sw_level  out  NUM_CH  debounced level
sw_rise  out  NUM_CH  one-cycle pulse when sw_level goes 0->1
sw_fall  out  NUM_CH  one-cycle pulse when sw_level goes 1->0
sw_toggle  out  NUM_CH  flips on every accepted rise

Behaviour:
- Interface: one clock, clk_125. Reset reset_n is asynchronous and active-low. All flops are reset by reset_n.
- Reset values: sync flops 0, state STABLE_LO, counters 0, and sw_level/sw_rise/sw_fall/sw_toggle all 0. Assertion mid-operation clears these immediately. A pending transition is discarded.
- Synchronizer: 2 flops per channel (sync1, sync2). s = sync2 is the only signal the FSM uses.
- Per-channel FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- STABLE_LO: if s=1, go to PEND_HI and set cnt<=0. Otherwise hold.
- PEND_HI with s=0: return to STABLE_LO, cnt<=0. No event.
- PEND_HI with s=1 and cnt!=DEBOUNCE_CYCLES-1: cnt<=cnt+1.
- PEND_HI with s=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, sw_level<=1, sw_rise<=1 for exactly one cycle, sw_toggle<=~sw_toggle.
- STABLE_HI/PEND_LO: mirror image of the above. Acceptance sets sw_level<=0 and pulses sw_fall. sw_toggle is unchanged on fall.
- Latency: with the raw input stable, sw_level and the pulse update on the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge that first samples sw_in.
- sw_rise/sw_fall are registered. They are never both high on one channel, and never high on two consecutive cycles.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES cycles (after sync) produces no output change.
- Bounce: each reversal during a PEND state restarts qualification from the stable state.
- Counter: saturates logically via the state change and never wraps. The counter is only active in PEND states.
- Channels are fully independent. Simultaneous transitions on several channels yield same-cycle pulses on each.

Decomposition:
- Package switch_pkg:
  - sw_state_t enum {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO}, 2 bits
  - CLK_FREQ_HZ = 125000000
  - DEFAULT_DEBOUNCE_MS = 20
- Sub-module debounce_channel: one channel, containing synchronizer, FSM, counter and toggle. The top module generate-loops it NUM_CH times.

Test Plan (DEBOUNCE_CYCLES=8, NUM_CH=4):
- Reset: hold reset_n=0 with sw_in=4'hF -> all outputs 0. Then drop reset_n low asynchronously mid-qualification -> outputs 0 with no clock edge, and no pulse after release until requalified.
- Clean press: sw_in[0] 0->1 held -> sw_level[0]=1 and sw_rise[0]=1 on edge 11, sw_rise[0]=0 on edge 12, sw_toggle[0]=1, other channels 0.
- Glitch: sw_in[1] high for 5 cycles then low -> sw_level/sw_rise/sw_fall/sw_toggle stay 4'h0 for the next 20 cycles.
- Bounce: sw_in[2] toggles every 3 cycles for 30 cycles, then held 1 -> exactly one sw_rise[2] pulse, on edge 11 after the final 0->1.
- Release and re-press: from stable high on channel 0, set sw_in[0]=0 -> sw_fall[0] pulse on edge 11, sw_toggle[0] stays 1. Re-press -> sw_rise[0] pulse, sw_toggle[0]=0.
- Simultaneous: sw_in 4'h0->4'hF -> sw_rise=4'hF and sw_level=4'hF on the same edge 11.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and clock/timing constants for the switch debouncer.
package switch_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } sw_state_t;

    localparam int CLK_FREQ_HZ         = 125000000;
    localparam int DEFAULT_DEBOUNCE_MS = 20;

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundles raw switch pins and their cleaned outputs; master drives the pins,
// slave is the debouncer.
interface switch_debouncer_if #(
    parameter int NUM_CH = 4
);
    import switch_pkg::*;

    logic [NUM_CH-1:0] sw_in;
    logic [NUM_CH-1:0] sw_level;
    logic [NUM_CH-1:0] sw_rise;
    logic [NUM_CH-1:0] sw_fall;
    logic [NUM_CH-1:0] sw_toggle;

    modport master (
        output sw_in,
        input  sw_level, sw_rise, sw_fall, sw_toggle
    );

    modport slave (
        input  sw_in,
        output sw_level, sw_rise, sw_fall, sw_toggle
    );

endinterface

// File: rtl/switch_debouncer_channel.sv
// One debounced switch channel: 2-FF synchronizer, qualification FSM with
// counter, registered rise/fall pulses and a press-toggle bit.
module debounce_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    sw_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             toggle_q;

    // Any reversal while pending drops back to the stable state, so the
    // counter never needs to wrap: reaching CNT_LAST always leaves the PEND state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= PEND_HI;
                        cnt_q   <= '0;
                    end
                end
                PEND_HI: begin
                    if (!sync2_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= STABLE_HI;
                        cnt_q    <= '0;
                        level_q  <= 1'b1;
                        rise_q   <= 1'b1;
                        toggle_q <= ~toggle_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        state_q <= PEND_LO;
                        cnt_q   <= '0;
                    end
                end
                PEND_LO: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/switch_debouncer.sv
// Top of the switch debouncer: NUM_CH independent debounce channels driven
// from raw pins and reporting through the switch bus interface.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEFAULT_DEBOUNCE_MS
) (
    input  logic                 clk_125,
    input  logic                 reset_n,
    switch_debouncer_if.slave    sw_bus
);

    logic [NUM_CH-1:0] levelVec;
    logic [NUM_CH-1:0] riseVec;
    logic [NUM_CH-1:0] fallVec;
    logic [NUM_CH-1:0] toggleVec;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clk_i   (clk_125),
            .rst_ni  (reset_n),
            .sw_i    (sw_bus.sw_in[ch]),
            .level_o (levelVec[ch]),
            .rise_o  (riseVec[ch]),
            .fall_o  (fallVec[ch]),
            .toggle_o(toggleVec[ch])
        );
    end

    assign sw_bus.sw_level  = levelVec;
    assign sw_bus.sw_rise   = riseVec;
    assign sw_bus.sw_fall   = fallVec;
    assign sw_bus.sw_toggle = toggleVec;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=8, NUM_CH=4;
// outputs are sampled 1 ns after each rising edge.
module tb_switch_debouncer;

    localparam int NUM_CH = 4;
    localparam int DEB    = 8;

    logic clk;
    logic rstN;
    int   errors;
    int   checks;
    logic [3:0] seenRise;
    logic [3:0] seenFall;

    switch_debouncer_if #(.NUM_CH(NUM_CH)) swIf ();

    switch_debouncer #(
        .NUM_CH(NUM_CH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_125(clk),
        .reset_n(rstN),
        .sw_bus (swIf)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while recording any pulses seen along the way.
    task automatic tickWatch(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            seenRise |= swIf.sw_rise;
            seenFall |= swIf.sw_fall;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pins);
        swIf.sw_in = pins;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        seenRise = '0;
        seenFall = '0;

        // Reset held with all pins high.
        rstN = 1'b0;
        applyStimulus(4'hF);
        repeat (3) tick();
        checkOutput("reset level", swIf.sw_level, 4'h0);
        checkOutput("reset rise", swIf.sw_rise, 4'h0);
        checkOutput("reset fall", swIf.sw_fall, 4'h0);
        checkOutput("reset toggle", swIf.sw_toggle, 4'h0);
        applyStimulus(4'h0);
        rstN = 1'b1;
        repeat (4) tick();

        // Clean press on channel 0.
        applyStimulus(4'h1);
        seenRise = '0;
        tickWatch(10);
        checkOutput("press early rise", seenRise, 4'h0);
        checkOutput("press early level", swIf.sw_level, 4'h0);
        tick();
        checkOutput("press level e11", swIf.sw_level, 4'h1);
        checkOutput("press rise e11", swIf.sw_rise, 4'h1);
        checkOutput("press toggle e11", swIf.sw_toggle, 4'h1);
        checkOutput("press fall e11", swIf.sw_fall, 4'h0);
        tick();
        checkOutput("press rise e12", swIf.sw_rise, 4'h0);
        checkOutput("press level e12", swIf.sw_level, 4'h1);

        // Five-cycle glitch on channel 1.
        seenRise = '0;
        seenFall = '0;
        applyStimulus(4'h3);
        tickWatch(5);
        applyStimulus(4'h1);
        tickWatch(20);
        checkOutput("glitch rise", seenRise, 4'h0);
        checkOutput("glitch fall", seenFall, 4'h0);
        checkOutput("glitch level", swIf.sw_level, 4'h1);
        checkOutput("glitch toggle", swIf.sw_toggle, 4'h1);

        // Channel 2 bounces every 3 cycles, ending low, then settles high.
        seenRise = '0;
        seenFall = '0;
        for (int seg = 0; seg < 10; seg++) begin
            applyStimulus({1'b0, (seg % 2 == 0), 1'b0, 1'b1});
            tickWatch(3);
        end
        applyStimulus(4'h5);
        tickWatch(10);
        checkOutput("bounce early rise", seenRise, 4'h0);
        checkOutput("bounce early fall", seenFall, 4'h0);
        tick();
        checkOutput("bounce rise e11", swIf.sw_rise, 4'h4);
        checkOutput("bounce level e11", swIf.sw_level, 4'h5);
        checkOutput("bounce toggle e11", swIf.sw_toggle, 4'h5);
        seenRise = '0;
        tickWatch(6);
        checkOutput("bounce single rise", seenRise, 4'h0);

        // Release channel 0, then press it again.
        applyStimulus(4'h4);
        seenFall = '0;
        tickWatch(10);
        checkOutput("release early fall", seenFall, 4'h0);
        tick();
        checkOutput("release fall e11", swIf.sw_fall, 4'h1);
        checkOutput("release level e11", swIf.sw_level, 4'h4);
        checkOutput("release toggle e11", swIf.sw_toggle, 4'h5);
        tick();
        checkOutput("release fall e12", swIf.sw_fall, 4'h0);
        applyStimulus(4'h5);
        repeat (10) tick();
        checkOutput("repress early level", swIf.sw_level, 4'h4);
        tick();
        checkOutput("repress rise e11", swIf.sw_rise, 4'h1);
        checkOutput("repress toggle e11", swIf.sw_toggle, 4'h4);

        // Drop everything, then press all four channels together.
        applyStimulus(4'h0);
        repeat (11) tick();
        checkOutput("all release fall", swIf.sw_fall, 4'h5);
        repeat (3) tick();
        applyStimulus(4'hF);
        repeat (10) tick();
        checkOutput("simul early level", swIf.sw_level, 4'h0);
        tick();
        checkOutput("simul rise e11", swIf.sw_rise, 4'hF);
        checkOutput("simul level e11", swIf.sw_level, 4'hF);
        checkOutput("simul toggle e11", swIf.sw_toggle, 4'hB);
        tick();
        checkOutput("simul rise e12", swIf.sw_rise, 4'h0);

        // Asynchronous reset in the middle of a release qualification.
        applyStimulus(4'h0);
        repeat (5) tick();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async level", swIf.sw_level, 4'h0);
        checkOutput("async toggle", swIf.sw_toggle, 4'h0);
        checkOutput("async fall", swIf.sw_fall, 4'h0);
        repeat (2) tick();
        applyStimulus(4'hF);
        rstN = 1'b1;
        seenRise = '0;
        seenFall = '0;
        tickWatch(10);
        checkOutput("post reset early rise", seenRise, 4'h0);
        checkOutput("post reset early fall", seenFall, 4'h0);
        tick();
        checkOutput("post reset rise e11", swIf.sw_rise, 4'hF);
        checkOutput("post reset level e11", swIf.sw_level, 4'hF);
        checkOutput("post reset toggle e11", swIf.sw_toggle, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
